mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter ITERS, default 32, number of iteration cycles per operation; only 32 is supported.
REQ-002 SHALL provide port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports data_operandA, data_operandB  input  32 each  signed two's-complement operands (A = multiplicand/dividend, B = multiplier/divisor).
REQ-005 SHALL provide port ctrl_MULT  input  1  start-multiply strobe, sampled on rising edge.
REQ-006 SHALL provide port ctrl_DIV  input  1  start-divide strobe, sampled on rising edge.
REQ-007 SHALL provide port data_result  output  32  signed result.
REQ-008 SHALL provide port data_exception  output  1  overflow / divide-error flag, valid with data_resultRDY.
REQ-009 SHALL provide port data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port busy  output  1  high while an operation is in progress (MUL or DIV state).

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, DONE; IDLE->MUL on ctrl_MULT, IDLE->DIV on ctrl_DIV, MUL/DIV->DONE after 32 iterations, DONE->IDLE unless a new strobe is sampled.
REQ-012 SHALL latch both operands on the start edge; later operand changes SHALL NOT affect the operation.
REQ-013 SHALL perform one iteration per clock (shift-add / Booth for multiply, restoring shift-subtract for divide) using a 33-bit add/subtract datapath.
REQ-014 SHALL assert data_resultRDY for exactly one cycle, starting 32 rising edges after the start edge (start at edge T -> RDY high between edges T+32 and T+33).
REQ-015 Multiply SHALL return the low 32 bits of the signed 64-bit product; data_exception=1 iff the product does not fit in signed 32 bits.
REQ-016 Divide SHALL return the signed quotient truncated toward zero; the remainder is discarded.
REQ-017 Divide by zero SHALL return data_result=0 with data_exception=1, at the normal latency.
REQ-018 Divide 0x80000000 / 0xFFFFFFFF SHALL return 0x80000000 with data_exception=1.
REQ-019 If ctrl_MULT and ctrl_DIV are sampled high together, multiply SHALL take priority.
REQ-020 Strobes sampled while in MUL or DIV SHALL be ignored, with no effect on the current operation.
REQ-021 A strobe sampled in the DONE cycle SHALL start a new operation back-to-back, without passing through IDLE.
REQ-022 data_result and data_exception SHALL hold their final values after RDY until the next RDY, and SHALL NOT show intermediate values.
REQ-023 busy SHALL be high exactly in MUL and DIV, and low in IDLE and DONE.

Reset
REQ-024 Reset SHALL asynchronously force state IDLE, iteration counter 0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 Reset asserted mid-operation SHALL abort it, and no RDY pulse SHALL follow for the aborted operation.
REQ-026 The first strobe sampled after reset deassertion SHALL be accepted normally.

Structure
REQ-027 State encodings (2-bit), ITERS=32, and counter width (6 bits) SHALL live in a shared package/include used by the unit and its bench.
REQ-028 The 33-bit add/subtract datapath SHALL be a separate sub-module named md_addsub (inputs a, b, sub; outputs sum, carry).
REQ-029 Sign correction for divide SHALL be applied before and after the iteration loop, outside md_addsub.

Verification
REQ-030 ctrl_MULT with A=7, B=-6 -> RDY exactly 32 edges later, data_result=0xFFFFFFD6 (-42), exception=0.
REQ-031 ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1.
REQ-032 ctrl_DIV with A=-7, B=2 -> data_result=0xFFFFFFFD (-3), exception=0; and A=5, B=0 -> data_result=0, exception=1.
REQ-033 ctrl_DIV with A=10, B=3, then ctrl_MULT pulsed at cycle 5 -> strobe ignored, single RDY with data_result=3, busy low in the RDY cycle.
REQ-034 ctrl_MULT A=3, B=4, then ctrl_DIV A=100, B=-10 in the RDY cycle -> RDY with 12, then RDY 32 edges later with 0xFFFFFFF6.
REQ-035 reset pulsed at iteration 10 of a divide -> all outputs 0 immediately, no RDY pulse within 40 cycles; the next ctrl_MULT 2*2 returns 4.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mult_div_pkg;

   localparam int MD_ITERS = 32;
   localparam int CNT_W    = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_e;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_addsub.sv
// 33-bit adder/subtractor shared by the Booth and restoring-divide steps.
module md_addsub (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        sub,
   output logic [32:0] sum,
   output logic        carry
);

   logic [33:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b ^ {33{sub}}} + {33'd0, sub};
   end

   assign sum   = full[32:0];
   assign carry = full[33];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring),
// one step per clock, 32 steps per operation.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int ITERS = MD_ITERS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   md_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt;
   logic [32:0]      acc;
   logic [31:0]      mq;
   logic             q_1;
   logic [31:0]      mcand;
   logic             neg_q;
   logic             div_zero;
   logic             div_ovf;

   logic [32:0] as_a, as_b, as_sum, bsum;
   logic        as_sub, as_carry;
   logic [32:0] nxt_acc;
   logic [31:0] nxt_mq;
   logic        nxt_q1;
   logic        last, start;
   logic [31:0] fin_res;
   logic        fin_exc;

   md_addsub u_addsub (
      .a     (as_a),
      .b     (as_b),
      .sub   (as_sub),
      .sum   (as_sum),
      .carry (as_carry)
   );

   assign last  = (cnt == CNT_W'(ITERS - 1));
   assign start = ((state_q == S_IDLE) || (state_q == S_DONE))
                  && (ctrl_MULT || ctrl_DIV);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (ctrl_MULT)     state_d = S_MUL;
            else if (ctrl_DIV) state_d = S_DIV;
            else               state_d = S_IDLE;
         end
         S_MUL, S_DIV: begin
            if (last) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Divide step: trial-subtract divisor from shifted remainder; carry=1 means no borrow.
   always_comb begin
      as_a    = {acc[31:0], mq[31]};
      as_b    = {1'b0, mcand};
      as_sub  = 1'b1;
      bsum    = acc;
      nxt_acc = acc;
      nxt_mq  = mq;
      nxt_q1  = q_1;
      if (state_q == S_MUL) begin
         as_a    = acc;
         as_b    = {mcand[31], mcand};
         as_sub  = mq[0];
         bsum    = (mq[0] ^ q_1) ? as_sum : acc;
         nxt_acc = {bsum[32], bsum[32:1]};
         nxt_mq  = {bsum[0], mq[31:1]};
         nxt_q1  = mq[0];
      end else if (state_q == S_DIV) begin
         nxt_acc = as_carry ? as_sum : as_a;
         nxt_mq  = {mq[30:0], as_carry};
      end
   end

   always_comb begin
      fin_res = nxt_mq;
      fin_exc = 1'b0;
      if (state_q == S_MUL) begin
         fin_exc = (nxt_acc[31:0] != {32{nxt_mq[31]}});
      end else if (div_zero) begin
         fin_res = 32'd0;
         fin_exc = 1'b1;
      end else begin
         fin_res = neg_q ? (~nxt_mq + 32'd1) : nxt_mq;
         fin_exc = div_ovf;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         acc            <= '0;
         mq             <= '0;
         q_1            <= 1'b0;
         mcand          <= '0;
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (start) begin
         cnt      <= '0;
         acc      <= '0;
         q_1      <= 1'b0;
         neg_q    <= data_operandA[31] ^ data_operandB[31];
         div_zero <= (data_operandB == 32'd0);
         div_ovf  <= (data_operandA == 32'h8000_0000)
                     && (data_operandB == 32'hFFFF_FFFF);
         if (ctrl_MULT) begin
            mq    <= data_operandB;
            mcand <= data_operandA;
         end else begin
            mq    <= abs32(data_operandA);
            mcand <= abs32(data_operandB);
         end
      end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
         cnt <= cnt + CNT_W'(1);
         acc <= nxt_acc;
         mq  <= nxt_mq;
         q_1 <= nxt_q1;
         if (last) begin
            data_result    <= fin_res;
            data_exception <= fin_exc;
         end
      end
   end

   assign busy           = (state_q == S_MUL) || (state_q == S_DIV);
   assign data_resultRDY = (state_q == S_DONE);

endmodule
